demux_4_fifo: RTL

Registered 1-to-4 demultiplexer with a 2-entry FIFO per output lane and valid/ready handshakes on both sides. It routes one producer stream, such as a writeback or result bus, to one of four consumer lanes chosen per transfer by `in_sel`. It is the distributing counterpart to the `mux_4` selector. Each lane buffers independently, so a stalled consumer blocks only transfers addressed to that lane.

---
 rtl/demux_4_fifo.sv | 104 ++++++++++
 1 files changed

// File: rtl/demux_4_fifo.sv
// Registered 1-to-4 demultiplexer: one producer stream routed per transfer to
// one of four independent 2-entry lane FIFOs, valid/ready on both sides.

module demux_4_fifo_lane #(
  parameter int LENGTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [LENGTH-1:0] data_i,
  output logic [LENGTH-1:0] data_o,
  output logic              valid_o,
  output logic [1:0]        cnt_o
);
  logic [LENGTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]        cnt_q, cnt_d;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    unique case ({push_i, pop_i})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = data_i;
        else               tail_d = data_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      // push is only offered below count 2, so a dual op here means count 1
      2'b11: begin
        head_d = (cnt_q == 2'd1) ? data_i : tail_q;
        tail_d = data_i;
      end
      default: ;
    endcase
    if (flush_i) cnt_d = 2'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign valid_o = (cnt_q != 2'd0);
  assign data_o  = valid_o ? head_q : '0;
  assign cnt_o   = cnt_q;
endmodule

module demux_4_fifo #(
  parameter int LENGTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [LENGTH-1:0]   in_data,
  input  logic [1:0]          in_sel,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                flush,
  output logic [4*LENGTH-1:0] out_data,
  output logic [3:0]          out_valid,
  input  logic [3:0]          out_ready,
  output logic [7:0]          out_count
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0][LENGTH-1:0] lane_data;
  logic [NUM_LANES-1:0][1:0]        lane_cnt;
  logic [NUM_LANES-1:0]             lane_valid;
  logic                             push;

  // in_ready never looks at out_ready: a full lane refuses even if it pops now
  assign in_ready = !flush && (lane_cnt[in_sel] != 2'd2);
  assign push     = in_valid && in_ready;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    demux_4_fifo_lane #(.LENGTH(LENGTH)) u_lane (
      .clk     (clk),
      .reset   (reset),
      .flush_i (flush),
      .push_i  (push && (in_sel == 2'(k))),
      .pop_i   (lane_valid[k] && out_ready[k]),
      .data_i  (in_data),
      .data_o  (lane_data[k]),
      .valid_o (lane_valid[k]),
      .cnt_o   (lane_cnt[k])
    );
  end

  assign out_data  = lane_data;
  assign out_valid = lane_valid;
  assign out_count = lane_cnt;
endmodule
